// File: rtl/decr_sequencer_pkg.sv
// decr_sequencer_pkg: shared definitions for the decrementing stream sequencer.
//   state_t       - two-state sequencer FSM encoding (IDLE, EMIT)
//   DEFAULT_WIDTH - default bit width of the start value and count
package decr_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage : decr_sequencer_pkg

// File: rtl/decr_sequencer_decr.sv
// decr_module: combinational WIDTH-bit subtract-one, modulo 2^WIDTH.
//   from   - operand
//   result - from - 1 (no borrow out; callers never apply it to zero)
module decr_module #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] from,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign result = from - ONE;

endmodule : decr_module

// File: rtl/decr_sequencer.sv
// decr_sequencer: accepts one start value over a valid/ready input and emits
// start, start-1, ..., 0 on a valid/ready output stream, flagging the 0 beat.
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   in_valid  - start value present on in_data
//   in_ready  - block can accept a start value (IDLE and not in reset)
//   in_data   - start value, unsigned
//   out_valid - current beat valid (EMIT)
//   out_ready - downstream accepts the current beat
//   out_data  - current count value (straight from the count register)
//   out_last  - current beat is the final one (count == 0)
//   busy      - a sequence is in progress
module decr_sequencer
  import decr_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] next_count_s;
  logic [WIDTH-1:0] dec_count_s;

  decr_module #(
    .WIDTH (WIDTH)
  ) u_decr (
    .from   (count_r),
    .result (dec_count_s)
  );

  // Data outputs come only from the count register; out_ready never reaches them.
  assign out_data = count_r;

  // State and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= ZERO;
    end else begin
      state_r <= next_state_s;
      count_r <= next_count_s;
    end
  end

  // Next-state, next-count and handshake outputs.
  always_comb begin
    next_state_s = state_r;
    next_count_s = count_r;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b0;
    case (state_r)
      IDLE: begin
        // in_ready is held low during reset so no load is advertised then.
        in_ready = ~reset;
        if (in_valid && !reset) begin
          next_state_s = EMIT;
          next_count_s = in_data;
        end else begin
          next_state_s = IDLE;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (count_r == ZERO);
        if (out_ready) begin
          // Zero ends the sequence and is never decremented, so the count cannot wrap.
          if (count_r == ZERO) begin
            next_state_s = IDLE;
          end else begin
            next_count_s = dec_count_s;
          end
        end else begin
          next_state_s = EMIT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule : decr_sequencer

// File: tb/tb_decr_sequencer.sv
// tb_decr_sequencer: directed self-checking bench for decr_sequencer.
module tb_decr_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int total = 0;
  int bad   = 0;

  decr_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] n);
    in_valid = 1'b1;
    in_data  = n;
    chk("load_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  // Consume a sequence starting at n; with stall set, out_ready follows 1,0,0,1,0,0,...
  task automatic drain(input int n, input bit stall);
    int  exp_v = n;
    int  beats = 0;
    int  cyc   = 0;
    bit  done  = 1'b0;
    logic [7:0] exp_b;
    while (!done && cyc < 2000) begin
      exp_b = exp_v[7:0];
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_data", {24'd0, out_data}, {24'd0, exp_b});
      chk("beat_last", {31'd0, out_last}, (exp_v == 0) ? 32'd1 : 32'd0);
      chk("beat_busy", {31'd0, busy}, 32'd1);
      chk("beat_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      step();
      cyc++;
      if (out_ready) begin
        beats++;
        if (exp_v == 0) done = 1'b1;
        else exp_v--;
      end
    end
    chk("seq_done", {31'd0, done}, 32'd1);
    chk("seq_beats", beats, n + 1);
    chk("after_valid", {31'd0, out_valid}, 32'd0);
    chk("after_busy", {31'd0, busy}, 32'd0);
    chk("after_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // in_data without in_valid must not start anything.
    in_data = 8'd7;
    step();
    chk("no_valid_idle", {31'd0, out_valid}, 32'd0);

    // Load 3, out_ready held high.
    load(8'd3);
    drain(3, 1'b0);

    // Load 0: single final beat.
    load(8'd0);
    drain(0, 1'b0);

    // Load 5 with back-pressure.
    load(8'd5);
    drain(5, 1'b1);

    // Load 255: full range, no wrap after 0.
    load(8'd255);
    drain(255, 1'b0);

    // in_valid held with data 9 across a load-4 sequence.
    in_valid = 1'b1;
    in_data  = 8'd4;
    step();
    in_data  = 8'd9;
    drain(4, 1'b0);
    step();
    in_valid = 1'b0;
    in_data  = 8'd0;
    drain(9, 1'b0);

    // Reset while out_data is 2 in a load-6 sequence.
    load(8'd6);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_data", {24'd0, out_data}, 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_data", {24'd0, out_data}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    step();
    chk("mid_rst_stays_idle", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_decr_sequencer
